// File: rtl/riscv_cpu_pkg.sv
// -----------------------------------------------------------------------------
// riscv_cpu_pkg
// Shared constants for the CPU front end.
//   INSTR_NOP        : canonical no-op (addi x0, x0, 0), shown to decode when
//                      the fetch stage has nothing valid to offer.
//   FETCH_FIFO_DEPTH : default instruction buffer depth, which is also the
//                      default limit on in-flight fetch requests.
// -----------------------------------------------------------------------------
package riscv_cpu_pkg;
   localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
   localparam int          FETCH_FIFO_DEPTH = 2;
endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous shift-register FIFO. Entry 0 is always the head, so data_o comes
// straight from a register. Unused entries hold EMPTY_VAL, so an empty FIFO
// presents EMPTY_VAL on data_o. Flush beats push and pop. A push while full
// and a pop while empty are ignored.
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset
//   push_i, data_i    : write a word at the tail
//   pop_i             : drop the head word
//   flush_i           : empty the FIFO
//   data_o            : head word (EMPTY_VAL when empty)
//   full_o, empty_o   : status (empty_o is a register)
//   count_o           : number of stored words
// -----------------------------------------------------------------------------
module fetch_fifo
   import riscv_cpu_pkg::*;
#(
   parameter int               DEPTH     = FETCH_FIFO_DEPTH,
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] EMPTY_VAL = '0,
   localparam int              CW        = $clog2(DEPTH) + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] r_mem   [DEPTH];
   logic [WIDTH-1:0] w_shift [DEPTH];
   logic [WIDTH-1:0] w_mem_n [DEPTH];
   logic [CW-1:0]    r_count;
   logic [CW-1:0]    w_count_n;
   logic [CW-1:0]    w_wr_idx;
   logic             r_empty;
   logic             w_push;
   logic             w_pop;

   assign w_push   = push_i && (r_count != CW'(DEPTH));
   assign w_pop    = pop_i && !r_empty;
   // After a pop the tail slot moves down by one.
   assign w_wr_idx = r_count - CW'(w_pop);

   // Storage contents shifted down by one entry, refilling the top with EMPTY_VAL.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         w_shift[i] = EMPTY_VAL;
      end
      for (int i = 0; i < DEPTH - 1; i++) begin
         w_shift[i] = r_mem[i + 1];
      end
   end

   // Next-state for storage and occupancy.
   always_comb begin
      w_count_n = r_count;
      for (int i = 0; i < DEPTH; i++) begin
         w_mem_n[i] = r_mem[i];
      end
      if (flush_i) begin
         w_count_n = '0;
         for (int i = 0; i < DEPTH; i++) begin
            w_mem_n[i] = EMPTY_VAL;
         end
      end else begin
         w_count_n = r_count + CW'(w_push) - CW'(w_pop);
         for (int i = 0; i < DEPTH; i++) begin
            if (w_push && (w_wr_idx == CW'(i))) begin
               w_mem_n[i] = data_i;
            end else if (w_pop) begin
               w_mem_n[i] = w_shift[i];
            end else begin
               w_mem_n[i] = r_mem[i];
            end
         end
      end
   end

   // Storage, occupancy and registered empty flag.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_count <= '0;
         r_empty <= 1'b1;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= EMPTY_VAL;
         end
      end else begin
         r_count <= w_count_n;
         r_empty <= (w_count_n == '0);
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= w_mem_n[i];
         end
      end
   end

   assign data_o  = r_mem[0];
   assign full_o  = (r_count == CW'(DEPTH));
   assign empty_o = r_empty;
   assign count_o = r_count;

endmodule

// File: rtl/fetch_unit_chk.sv
// -----------------------------------------------------------------------------
// fetch_unit_chk
// Protocol checks for fetch_unit.
// Ports:
//   clk_i, rst_i    : clock, synchronous active-high reset
//   rvalid_i        : memory response valid
//   push_i, full_i  : FIFO push request and FIFO full flag
//   outstanding_i   : granted requests that are still awaiting a response
//   discard_i       : in-flight responses still to be dropped
// -----------------------------------------------------------------------------
module fetch_unit_chk #(
   parameter int CW = 2
) (
   input logic          clk_i,
   input logic          rst_i,
   input logic          rvalid_i,
   input logic          push_i,
   input logic          full_i,
   input logic [CW-1:0] outstanding_i,
   input logic [CW-1:0] discard_i
);

   // Sample the protocol rules on every clock outside reset.
   always @(posedge clk_i) begin
      if (!rst_i) begin
         assert (!(rvalid_i && (outstanding_i == '0) && (discard_i == '0)))
            else $error("fetch_unit: rvalid with no request in flight");
         assert (!(push_i && full_i))
            else $error("fetch_unit: push into a full instruction buffer");
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage. It holds the fetch PC and issues word requests over
// req/gnt/rvalid. Returned words are buffered in fetch_fifo and handed to
// decode with their PC over valid/ready. A redirect flushes the old path.
// Ports:
//   clk_i, rst_i                       : clock, synchronous active-high reset
//   instr_req_o/addr_o/gnt_i           : request side of the memory port
//   instr_rvalid_i/rdata_i             : response side of the memory port
//   redirect_i/redirect_addr_i         : jump or taken-branch target
//   instr_valid_o/ready_i/instr_o/pc_o : decode handshake (all outputs registered
//                                        except instr_req_o)
// -----------------------------------------------------------------------------
module fetch_unit
   import riscv_cpu_pkg::*;
#(
   parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
   parameter int          FIFO_DEPTH = FETCH_FIFO_DEPTH
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        instr_req_o,
   output logic [31:0] instr_addr_o,
   input  logic        instr_gnt_i,
   input  logic        instr_rvalid_i,
   input  logic [31:0] instr_rdata_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_addr_i,
   output logic        instr_valid_o,
   input  logic        instr_ready_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o
);

   localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

   logic [31:0]   r_fetch_pc, w_fetch_pc_n;
   logic [31:0]   r_head_pc,  w_head_pc_n;
   // The discard counter only counts the responses that were in flight at a
   // redirect. The memory is therefore expected to keep the total in flight
   // within its range.
   logic [CW-1:0] r_outstanding, w_outstanding_n;
   logic [CW-1:0] r_discard,     w_discard_n;

   logic [31:0]   w_tgt;
   logic [CW-1:0] w_count;
   logic [CW:0]   w_credit;
   logic          w_empty, w_full, w_valid, w_pop, w_fire;
   logic          w_rsp_drop, w_rsp_keep, w_push;

   assign w_tgt   = redirect_addr_i & 32'hFFFF_FFFC;
   assign w_valid = !w_empty;
   assign w_pop   = w_valid && instr_ready_i;

   // Credit the word that decode takes this cycle, so that single-cycle
   // memory can sustain one instruction per clock.
   assign w_credit    = {1'b0, r_outstanding} + {1'b0, w_count} - (CW + 1)'(w_pop);
   assign instr_req_o = !rst_i && (w_credit < DEPTH_C);
   assign instr_addr_o = r_fetch_pc;
   assign w_fire      = instr_req_o && instr_gnt_i;

   // Stale responses drain first, because memory answers in order.
   assign w_rsp_drop = instr_rvalid_i && (r_discard != '0);
   assign w_rsp_keep = instr_rvalid_i && (r_discard == '0) && (r_outstanding != '0);
   assign w_push     = w_rsp_keep && !redirect_i;

   // Next-state for the PC registers and the credit and discard counters.
   always_comb begin
      w_fetch_pc_n    = r_fetch_pc;
      w_head_pc_n     = r_head_pc;
      w_outstanding_n = r_outstanding;
      w_discard_n     = r_discard;
      if (redirect_i) begin
         w_fetch_pc_n    = w_tgt;
         w_head_pc_n     = w_tgt;
         w_outstanding_n = '0;
         // Every request still in flight, including one granted now, turns
         // stale. A response arriving now has already left that total.
         w_discard_n     = r_discard + r_outstanding + CW'(w_fire)
                           - CW'(w_rsp_drop || w_rsp_keep);
      end else begin
         if (w_fire) begin
            w_fetch_pc_n = r_fetch_pc + 32'd4;
         end else begin
            w_fetch_pc_n = r_fetch_pc;
         end
         if (w_pop) begin
            w_head_pc_n = r_head_pc + 32'd4;
         end else begin
            w_head_pc_n = r_head_pc;
         end
         w_outstanding_n = r_outstanding + CW'(w_fire) - CW'(w_rsp_keep);
         w_discard_n     = r_discard - CW'(w_rsp_drop);
      end
   end

   // PC and counter registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_fetch_pc    <= BOOT_ADDR;
         r_head_pc     <= BOOT_ADDR;
         r_outstanding <= '0;
         r_discard     <= '0;
      end else begin
         r_fetch_pc    <= w_fetch_pc_n;
         r_head_pc     <= w_head_pc_n;
         r_outstanding <= w_outstanding_n;
         r_discard     <= w_discard_n;
      end
   end

   fetch_fifo #(
      .DEPTH     (FIFO_DEPTH),
      .WIDTH     (32),
      .EMPTY_VAL (INSTR_NOP)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (w_push),
      .pop_i   (w_pop && !redirect_i),
      .flush_i (redirect_i),
      .data_i  (instr_rdata_i),
      .data_o  (instr_o),
      .full_o  (w_full),
      .empty_o (w_empty),
      .count_o (w_count)
   );

   assign instr_valid_o = w_valid;
   assign pc_o          = r_head_pc;

   fetch_unit_chk #(
      .CW (CW)
   ) u_chk (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .rvalid_i      (instr_rvalid_i),
      .push_i        (w_push),
      .full_i        (w_full),
      .outstanding_i (r_outstanding),
      .discard_i     (r_discard)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed phases with randomized memory timing, decode ready and redirects.
// The reference model tracks the expected PC stream and the expected request
// address. A second instance checks PC wrap-around from a high boot address.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] KEY  = 32'hA5A5_0000;
   localparam logic [31:0] WBOOT = 32'hFFFF_FFF8;
   localparam int          FD   = 2;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        instr_req_o, instr_gnt_i, instr_rvalid_i, redirect_i;
   logic        instr_valid_o, instr_ready_i;
   logic [31:0] instr_addr_o, instr_rdata_i, redirect_addr_i, instr_o, pc_o;

   logic        wr_req, wr_gnt, wr_rvalid, wr_redirect, wr_valid, wr_ready;
   logic [31:0] wr_addr, wr_rdata, wr_redirect_addr, wr_instr, wr_pc;

   always #5 clk_i = ~clk_i;

   fetch_unit u_dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
      .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
      .redirect_i(redirect_i), .redirect_addr_i(redirect_addr_i),
      .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
      .instr_o(instr_o), .pc_o(pc_o)
   );

   fetch_unit #(.BOOT_ADDR(WBOOT)) u_wrap (
      .clk_i(clk_i), .rst_i(rst_i),
      .instr_req_o(wr_req), .instr_addr_o(wr_addr), .instr_gnt_i(wr_gnt),
      .instr_rvalid_i(wr_rvalid), .instr_rdata_i(wr_rdata),
      .redirect_i(wr_redirect), .redirect_addr_i(wr_redirect_addr),
      .instr_valid_o(wr_valid), .instr_ready_i(wr_ready),
      .instr_o(wr_instr), .pc_o(wr_pc)
   );

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int epoch = 0;
   int gnt_pct = 100, lat_lo = 1, lat_hi = 1;
   logic [31:0] q_addr[$];
   int          q_due[$];
   int          q_ep[$];
   logic [31:0] exp_pc = 32'h0, exp_fetch = 32'h0;
   logic        h_ok = 1'b0, rst_edge = 1'b0;
   logic [31:0] h_pc, h_instr;
   logic        last_req, last_valid, s_fire, s_rsp;
   logic [31:0] last_addr, last_pc;
   logic        wr_pend = 1'b0, wr_pend_n;
   logic [31:0] wr_pend_addr = 32'h0, wr_pend_addr_n;
   logic [31:0] wr_exp = WBOOT, wr_last = 32'h0;
   logic        wrap_seen = 1'b0;
   logic        found;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int cur_inflight();
      int n = 0;
      foreach (q_ep[i]) begin
         if (q_ep[i] == epoch) n++;
      end
      return n;
   endfunction

   // One clock cycle: drive the memories, sample and check against the model, then advance.
   task automatic tick();
      logic popped;
      instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = 32'h0;
      s_rsp = 1'b0;
      if (rst_i) begin
         q_addr.delete(); q_due.delete(); q_ep.delete();
      end else begin
         instr_gnt_i = ($urandom_range(99) < gnt_pct);
         if (q_addr.size() != 0 && q_due[0] <= cyc) begin
            instr_rvalid_i = 1'b1;
            instr_rdata_i  = q_addr[0] ^ KEY;
            void'(q_addr.pop_front()); void'(q_due.pop_front()); void'(q_ep.pop_front());
            s_rsp = 1'b1;
         end
      end
      wr_gnt = 1'b1; wr_rvalid = wr_pend && !rst_i; wr_rdata = wr_pend_addr ^ KEY;
      #1;
      last_req = instr_req_o; last_addr = instr_addr_o;
      last_valid = instr_valid_o; last_pc = pc_o;
      s_fire = instr_req_o && instr_gnt_i;
      if (rst_i) begin
         chk("rst_req", 32'(instr_req_o), 32'd0);
         if (rst_edge) begin
            chk("rst_valid", 32'(instr_valid_o), 32'd0);
            chk("rst_instr", instr_o, NOP);
            chk("rst_pc", pc_o, 32'h0);
            chk("rst_wrap_pc", wr_pc, WBOOT);
         end
         exp_pc = 32'h0; exp_fetch = 32'h0; h_ok = 1'b0;
         wr_exp = WBOOT; epoch++;
      end else begin
         if (!instr_valid_o) chk("nop_idle", instr_o, NOP);
         if (h_ok) begin
            chk("hold_valid", 32'(instr_valid_o), 32'd1);
            chk("hold_pc", pc_o, h_pc);
            chk("hold_instr", instr_o, h_instr);
         end
         popped = instr_valid_o && instr_ready_i;
         if (popped) begin
            chk("pc_order", pc_o, exp_pc);
            chk("instr_data", instr_o, exp_pc ^ KEY);
            exp_pc = exp_pc + 32'd4;
         end
         if (s_fire) begin
            chk("req_addr", instr_addr_o, exp_fetch);
            exp_fetch = exp_fetch + 32'd4;
            q_addr.push_back(instr_addr_o);
            q_due.push_back(cyc + int'($urandom_range(lat_hi, lat_lo)));
            q_ep.push_back(epoch);
            chk("inflight_le_depth", 32'(cur_inflight() <= FD), 32'd1);
         end
         if (redirect_i) begin
            exp_pc = redirect_addr_i & 32'hFFFF_FFFC;
            exp_fetch = exp_pc;
            epoch++;
         end
         h_ok = instr_valid_o && !popped && !redirect_i;
         h_pc = pc_o; h_instr = instr_o;
         if (wr_valid) begin
            chk("wrap_pc", wr_pc, wr_exp);
            chk("wrap_instr", wr_instr, wr_exp ^ KEY);
            if (wr_exp == 32'h0 && wr_last == 32'hFFFF_FFFC) wrap_seen = 1'b1;
            wr_last = wr_exp;
            wr_exp = wr_exp + 32'd4;
         end
      end
      wr_pend_n = wr_req && !rst_i; wr_pend_addr_n = wr_addr;
      @(posedge clk_i); #1;
      rst_edge = rst_i; cyc++;
      wr_pend = wr_pend_n; wr_pend_addr = wr_pend_addr_n;
   endtask

   initial begin
      rst_i = 1'b1; instr_ready_i = 1'b1; redirect_i = 1'b0; redirect_addr_i = 32'h0;
      wr_ready = 1'b1; wr_redirect = 1'b0; wr_redirect_addr = 32'h0;
      instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = 32'h0;
      wr_gnt = 1'b0; wr_rvalid = 1'b0; wr_rdata = 32'h0;

      // Reset for three cycles.
      repeat (3) tick();
      rst_i = 1'b0;

      // Zero-wait streaming: valid from N+2, then no bubbles.
      gnt_pct = 100; lat_lo = 1; lat_hi = 1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (i == 0) begin
            chk("first_req", 32'(last_req), 32'd1);
            chk("first_addr", last_addr, 32'h0);
         end
         chk("stream_valid", 32'(last_valid), (i >= 2) ? 32'd1 : 32'd0);
      end

      // Backpressure for five cycles.
      instr_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_valid", 32'(last_valid), 32'd1);
      end
      instr_ready_i = 1'b1;
      repeat (10) tick();

      // Random memory timing, decode ready and redirects.
      gnt_pct = 60; lat_lo = 1; lat_hi = 3;
      for (int i = 0; i < 60; i++) begin
         instr_ready_i = ($urandom_range(99) < 70);
         redirect_i = ($urandom_range(99) < 5);
         redirect_addr_i = $urandom;
         tick();
      end
      redirect_i = 1'b0; instr_ready_i = 1'b1;

      // Redirect to 0x103 with two requests in flight.
      gnt_pct = 70; lat_lo = 2; lat_hi = 4;
      found = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (q_addr.size() == 2 && q_due[0] > cyc) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      chk("rd_setup", 32'(found), 32'd1);
      redirect_i = 1'b1; redirect_addr_i = 32'h0000_0103;
      tick();
      redirect_i = 1'b0;
      tick();
      chk("rd_req_next", 32'(last_req), 32'd1);
      chk("rd_addr_next", last_addr, 32'h0000_0100);
      found = 1'b0;
      for (int k = 0; k < 60; k++) begin
         tick();
         if (last_valid) begin
            found = 1'b1;
            break;
         end
      end
      chk("rd_first_seen", 32'(found), 32'd1);
      chk("rd_first_pc", last_pc, 32'h0000_0100);

      // Redirect coinciding with pop, push and grant.
      gnt_pct = 100; lat_lo = 1; lat_hi = 1;
      repeat (8) tick();
      redirect_i = 1'b1; redirect_addr_i = 32'h0000_0200;
      tick();
      redirect_i = 1'b0;
      chk("sim_pop", 32'(last_valid), 32'd1);
      chk("sim_push", 32'(s_rsp), 32'd1);
      chk("sim_gnt", 32'(s_fire), 32'd1);
      tick();
      chk("sim_empty_n1", 32'(last_valid), 32'd0);
      chk("sim_req_n1", 32'(last_req), 32'd1);
      chk("sim_addr_n1", last_addr, 32'h0000_0200);
      tick();
      chk("sim_empty_n2", 32'(last_valid), 32'd0);
      tick();
      chk("sim_valid_n3", 32'(last_valid), 32'd1);
      chk("sim_pc_n3", last_pc, 32'h0000_0200);

      // Reset in the middle of traffic abandons in-flight responses.
      repeat (3) tick();
      rst_i = 1'b1;
      repeat (2) tick();
      rst_i = 1'b0;
      tick();
      chk("post_rst_req", 32'(last_req), 32'd1);
      chk("post_rst_addr", last_addr, 32'h0);
      repeat (10) tick();

      chk("wrap_seen", 32'(wrap_seen), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

- Instruction fetch stage, directly upstream of the decoder/control unit; it supplies the `instr_i` word that control decodes.
- Holds the fetch PC and issues word requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned words in a small FIFO and presents them with their PC to decode over a valid/ready handshake.
- Accepts redirects for jumps and taken branches, flushing everything fetched down the old path.

## Interface
Parameters:
- `BOOT_ADDR`, default 32'h0000_0000: reset fetch address (word aligned).
- `FIFO_DEPTH`, default 2: instruction buffer entries; also the limit on in-flight requests. Power of two, ≥2.

Ports:
- `clk_i` in 1: clock. Single clock domain.
- `rst_i` in 1: reset. Synchronous, active-high.
- `instr_req_o` out 1: memory request.
- `instr_addr_o` out 32: request word address; bits [1:0] always 0.
- `instr_gnt_i` in 1: request accepted this cycle.
- `instr_rvalid_i` in 1: response data valid.
- `instr_rdata_i` in 32: response instruction word.
- `redirect_i` in 1: change of control flow from execute/jump logic.
- `redirect_addr_i` in 32: new PC; bits [1:0] are ignored and forced to 0.
- `instr_valid_o` out 1: `instr_o` and `pc_o` are valid.
- `instr_ready_i` in 1: decode accepts the word this cycle.
- `instr_o` out 32: instruction to decode; equals `INSTR_NOP` (32'h0000_0013) when not valid.
- `pc_o` out 32: PC of `instr_o`.

## Operation
- **State:**
  - `fetch_pc`: next address to request.
  - `head_pc`: PC of the FIFO head.
  - `outstanding`: granted requests with no response yet.
  - `discard`: in-flight responses that must be dropped.
  - FIFO of 32-bit words.
- **Request rule:**
  - Condition: `instr_req_o = !rst_i && (outstanding + count - pop) < FIFO_DEPTH`, where `pop = instr_valid_o && instr_ready_i`.
  - Because the condition credits the current pop, the stage sustains one instruction per cycle with single-cycle memory.
  - `instr_addr_o = fetch_pc`.
  - On `req && gnt`: `fetch_pc += 4` (wraps modulo 2^32) and `outstanding++`.
- **Response:**
  - On `rvalid` with `discard > 0`: drop the word and decrement `discard`.
  - Otherwise: push to the FIFO and decrement `outstanding`.
  - `rvalid` with nothing in flight is illegal; ignore it and flag it with an assertion.
  - A push when full cannot occur under the request rule; assert this.
- **Pop:**
  - `instr_valid_o = (count != 0)`.
  - On pop: `head_pc += 4`.
- **Redirect** (highest priority):
  - `fetch_pc` and `head_pc` load `{redirect_addr_i[31:2], 2'b00}`.
  - The FIFO is flushed.
  - `discard` becomes `discard + outstanding`, plus 1 if `req && gnt` in the same cycle; `outstanding` becomes 0.
  - A simultaneous push or pop is overridden; the words go to the old path and are lost.
  - An `rvalid` in the redirect cycle decrements the in-flight total before the transfer to `discard`.
- **Stall:** while `instr_ready_i` is low, `instr_o`/`pc_o` hold. Requests continue until credits run out.
- **Address stability:** `instr_addr_o` is stable while `req` is high without `gnt`, except on the cycle after a redirect, when it changes to the new target.

## Timing
- **Reset values** (registered; hold while `rst_i` is high, valid the cycle after):
  - `instr_req_o=0`, `instr_valid_o=0`, `instr_o=INSTR_NOP`, `pc_o=BOOT_ADDR`.
  - `fetch_pc=BOOT_ADDR`, FIFO empty, counters 0.
- **Reset mid-operation:** in-flight responses are abandoned. Memory must not return responses to pre-reset requests after reset.
- **Latency:** gnt in cycle N, rvalid in N+1 → `instr_valid_o` in N+2. The FIFO is registered, with no rvalid→valid bypass.
- **Redirect in cycle N:**
  - The first request to the new target appears in N+1.
  - The earliest valid new-path instruction appears in N+3.
- **Output paths:**
  - `instr_valid_o`, `instr_o` and `pc_o` are purely registered.
  - `instr_req_o` depends combinationally on `instr_ready_i`, through the credit term.

## Structure
- Add to `riscv_cpu_pkg`: `INSTR_NOP` and a `FETCH_FIFO_DEPTH` default constant.
- Counters are `$clog2(FIFO_DEPTH)+1` bits wide.
- Sub-module `fetch_fifo`:
  - Synchronous FIFO with push, pop, flush, full, empty and count.
  - Flush takes priority over push and pop.
  - Reused for the future data-side buffer.
- `fetch_unit` contains the PC registers, credit/discard counters and handshake glue.

## Test plan
- **Reset:** hold `rst_i` for 3 cycles → `req=0`, `valid=0`, `instr_o=0x13`, `pc_o=0`; first request at address 0x0 the cycle after release.
- **Streaming:** zero-wait memory returning `addr^0xA5A5_0000`, `ready` always 1 → one instruction per cycle with PCs 0x0, 0x4, 0x8…; no bubbles after the N+2 startup.
- **Backpressure:** `ready=0` for 5 cycles mid-stream → outputs hold; at most `FIFO_DEPTH` requests in flight; no loss or duplication after `ready` returns.
- **Redirect with traffic:**
  - Setup: random gnt/rvalid delays, `redirect_i` to 0x0000_0103 with 2 requests in flight.
  - Required response: both stale responses dropped; the next `pc_o` is 0x100; no old-path word is ever valid after the redirect.
- **Simultaneous events:** redirect in the same cycle as pop, push and gnt → FIFO empty next cycle; `discard` counts the granted request; the new stream starts at the target.
- **Wrap:** `BOOT_ADDR=32'hFFFF_FFF8` → PCs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
